// File: rtl/atanh_input_converter.sv
// Converts an IEEE-754 single-precision (x, y) pair to signed fixed point and
// flags saturation, NaN/Inf and atanh(y/x) domain errors before the CORDIC core.
module atanh_input_converter #(
  parameter int unsigned FRAC_BITS = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x_input,
  input  logic [31:0] y_input,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] x_fx,
  output logic [31:0] y_fx,
  output logic        sat_flag,
  output logic        nan_flag,
  output logic        dom_err
);

  localparam int unsigned W = 32;
  localparam logic [W-1:0] SAT_POS = 32'h7FFF_FFFF;

  typedef enum logic [2:0] {IDLE, CONV_X, CONV_Y, CHECK, OUT} state_e;

  // Returns {nan, sat, value}; value is already signed and saturated symmetrically.
  function automatic logic [W+1:0] conv_fp(input logic [31:0] f);
    logic [7:0]   e;
    logic [23:0]  m;
    int           s;
    logic [W-1:0] mag;
    logic         sat;
    logic         nan;
    e   = f[30:23];
    m   = {1'b1, f[22:0]};
    s   = int'(e) - 127 + int'(FRAC_BITS) - 23;
    mag = '0;
    sat = 1'b0;
    nan = 1'b0;
    if (e == 8'hFF) begin
      nan = 1'b1;
    end else if (e != 8'h00) begin
      // Bit 23 of m is set, so any left shift of 8 or more reaches 2^31.
      if (s >= 8) begin
        sat = 1'b1;
        mag = SAT_POS;
      end else if (s >= 0) begin
        mag = {8'd0, m} << 3'(s);
      end else if (s > -24) begin
        mag = {8'd0, m >> 5'(-s)};
      end
    end
    if (f[31]) mag = W'(-mag);
    return {nan, sat, mag};
  endfunction

  state_e       state_q, state_d;
  logic [W-1:0] x_raw_q, x_raw_d, y_raw_q, y_raw_d;
  logic [W-1:0] x_fx_q, x_fx_d, y_fx_q, y_fx_d;
  logic         sat_q, sat_d, nan_q, nan_d, dom_q, dom_d;
  logic         in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic [W+1:0] conv_res;
  logic [W-1:0] abs_y;

  always_comb begin
    conv_res = conv_fp((state_q == CONV_X) ? x_raw_q : y_raw_q);
    abs_y    = y_fx_q[W-1] ? W'(-y_fx_q) : y_fx_q;
  end

  // Next-state and datapath updates; registered outputs follow the next state.
  always_comb begin
    state_d = state_q;
    x_raw_d = x_raw_q;
    y_raw_d = y_raw_q;
    x_fx_d  = x_fx_q;
    y_fx_d  = y_fx_q;
    sat_d   = sat_q;
    nan_d   = nan_q;
    dom_d   = dom_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_raw_d = x_input;
          y_raw_d = y_input;
          x_fx_d  = '0;
          y_fx_d  = '0;
          sat_d   = 1'b0;
          nan_d   = 1'b0;
          dom_d   = 1'b0;
          state_d = CONV_X;
        end
      end
      CONV_X: begin
        x_fx_d  = conv_res[W-1:0];
        sat_d   = conv_res[W];
        nan_d   = conv_res[W+1];
        state_d = CONV_Y;
      end
      CONV_Y: begin
        y_fx_d  = conv_res[W-1:0];
        sat_d   = sat_q | conv_res[W];
        nan_d   = nan_q | conv_res[W+1];
        state_d = CHECK;
      end
      CHECK: begin
        dom_d   = ($signed(x_fx_q) <= 0) || nan_q || (abs_y >= x_fx_q);
        state_d = OUT;
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == OUT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      x_raw_q     <= '0;
      y_raw_q     <= '0;
      x_fx_q      <= '0;
      y_fx_q      <= '0;
      sat_q       <= 1'b0;
      nan_q       <= 1'b0;
      dom_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_raw_q     <= x_raw_d;
      y_raw_q     <= y_raw_d;
      x_fx_q      <= x_fx_d;
      y_fx_q      <= y_fx_d;
      sat_q       <= sat_d;
      nan_q       <= nan_d;
      dom_q       <= dom_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign x_fx      = x_fx_q;
  assign y_fx      = y_fx_q;
  assign sat_flag  = sat_q;
  assign nan_flag  = nan_q;
  assign dom_err   = dom_q;

endmodule

// File: tb/tb_atanh_input_converter.sv
// Directed bench for atanh_input_converter with hand-computed Q1.30 results.
module tb_atanh_input_converter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] x_input = '0;
  logic [31:0] y_input = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] x_fx, y_fx;
  logic        sat_flag, nan_flag, dom_err;

  int total  = 0;
  int passed = 0;

  atanh_input_converter #(.FRAC_BITS(30)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x_input(x_input), .y_input(y_input), .out_valid(out_valid),
    .out_ready(out_ready), .x_fx(x_fx), .y_fx(y_fx),
    .sat_flag(sat_flag), .nan_flag(nan_flag), .dom_err(dom_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Outputs that must all read zero/idle right after a reset edge.
  task automatic chk_idle_zero(input string tag);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".x_fx"}, x_fx, 32'd0);
    chk({tag, ".y_fx"}, y_fx, 32'd0);
    chk({tag, ".flags"}, 32'({sat_flag, nan_flag, dom_err}), 32'd0);
  endtask

  // One full transfer with out_ready held high; starts and ends in IDLE.
  task automatic xfer(input string tag, input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] ex, input logic [31:0] ey,
                      input logic es, input logic en, input logic ed);
    x_input  = x;
    y_input  = y;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({tag, ".busy"}, 32'(in_ready), 32'd0);
    tick();
    tick();
    chk({tag, ".not_yet"}, 32'(out_valid), 32'd0);
    tick();
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".x_fx"}, x_fx, ex);
    chk({tag, ".y_fx"}, y_fx, ey);
    chk({tag, ".sat"}, 32'(sat_flag), 32'(es));
    chk({tag, ".nan"}, 32'(nan_flag), 32'(en));
    chk({tag, ".dom"}, 32'(dom_err), 32'(ed));
    tick();
    chk({tag, ".idle_ready"}, 32'(in_ready), 32'd1);
    chk({tag, ".idle_valid"}, 32'(out_valid), 32'd0);
  endtask

  logic [31:0] held_x, held_y;

  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk_idle_zero("reset");

    xfer("one_055", 32'h3F800000, 32'h3F0CCCCD, 32'h40000000, 32'h23333340, 1'b0, 1'b0, 1'b0);
    xfer("neg_half", 32'h3F800000, 32'hBF000000, 32'h40000000, 32'hE0000000, 1'b0, 1'b0, 1'b0);
    xfer("milli", 32'h3F800000, 32'h3A83126F, 32'h40000000, 32'h0010624D, 1'b0, 1'b0, 1'b0);
    xfer("y_eq_x", 32'h3F800000, 32'h3F800000, 32'h40000000, 32'h40000000, 1'b0, 1'b0, 1'b1);
    xfer("neg_x", 32'hBF800000, 32'h3F400000, 32'hC0000000, 32'h30000000, 1'b0, 1'b0, 1'b1);
    xfer("sat_pos", 32'h3F800000, 32'h40000000, 32'h40000000, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b1);
    xfer("sat_neg", 32'h3F800000, 32'hC0000000, 32'h40000000, 32'h80000001, 1'b1, 1'b0, 1'b1);
    xfer("nan_y", 32'h3F800000, 32'h7FC00000, 32'h40000000, 32'h00000000, 1'b0, 1'b1, 1'b1);
    xfer("inf_x", 32'h7F800000, 32'h3F000000, 32'h00000000, 32'h20000000, 1'b0, 1'b1, 1'b1);
    xfer("denorm", 32'h3F800000, 32'h00000001, 32'h40000000, 32'h00000000, 1'b0, 1'b0, 1'b0);
    // 2^-31: shift of -24 drops every bit.
    xfer("underflow", 32'h3F800000, 32'h30000000, 32'h40000000, 32'h00000000, 1'b0, 1'b0, 1'b0);
    xfer("zero_x", 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1);

    // Stall in OUT for 10 cycles while new requests are offered.
    out_ready = 1'b0;
    x_input   = 32'h3F800000;
    y_input   = 32'h3F0CCCCD;
    in_valid  = 1'b1;
    tick();
    x_input = 32'h40400000;
    y_input = 32'hBF800000;
    tick();
    tick();
    tick();
    chk("stall.enter", 32'(out_valid), 32'd1);
    held_x = x_fx;
    held_y = y_fx;
    chk("stall.held_x0", held_x, 32'h40000000);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall.valid", 32'(out_valid), 32'd1);
      chk("stall.ready", 32'(in_ready), 32'd0);
      chk("stall.x", x_fx, 32'h40000000);
      chk("stall.y", y_fx, 32'h23333340);
      chk("stall.flags", 32'({sat_flag, nan_flag, dom_err}), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("stall.release_ready", 32'(in_ready), 32'd1);
    chk("stall.release_valid", 32'(out_valid), 32'd0);
    tick();
    tick();
    tick();
    chk("stall.single_xfer", 32'(out_valid), 32'd0);

    // Reset while in CONV_Y discards the pair.
    x_input  = 32'h3F800000;
    y_input  = 32'h3F000000;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle_zero("rst_convy");
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_convy.no_stale", 32'(out_valid), 32'd0);
    end

    // Reset while stalled in OUT.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("rst_out.in_out", 32'(out_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    chk_idle_zero("rst_out");
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_out.no_stale", 32'(out_valid), 32'd0);
    end

    // Reset beats in_valid on the same edge.
    rst      = 1'b1;
    in_valid = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("rst_prio.ready", 32'(in_ready), 32'd1);
    tick();
    tick();
    tick();
    chk("rst_prio.no_out", 32'(out_valid), 32'd0);

    // Flags from earlier pairs must not leak into a clean pair.
    xfer("clean_after", 32'h3F800000, 32'h3F400000, 32'h40000000, 32'h30000000, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/atanh_input_converter.md
ATANH_INPUT_CONVERTER -- requirements
Module: atanh_input_converter

Interface
REQ-001 Parameter FRAC_BITS, default 30, fraction bits of the signed 32-bit fixed-point output; legal range 24..30.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  x_input/y_input pair valid.
REQ-005 in_ready  output  1  block can accept a pair.
REQ-006 x_input  input  32  IEEE 754 single-precision denominator operand.
REQ-007 y_input  input  32  IEEE 754 single-precision numerator operand.
REQ-008 out_valid  output  1  converted pair and flags valid.
REQ-009 out_ready  input  1  downstream CORDIC core accepts result.
REQ-010 x_fx  output  32  signed fixed-point x (Q(31-FRAC_BITS).FRAC_BITS, two's complement).
REQ-011 y_fx  output  32  signed fixed-point y, same format.
REQ-012 sat_flag  output  1  either operand saturated.
REQ-013 nan_flag  output  1  either operand NaN or infinity.
REQ-014 dom_err  output  1  atanh(y/x) argument outside (-1,1).

Function
REQ-015 FSM states IDLE, CONV_X, CONV_Y, CHECK, OUT; reset state IDLE.
REQ-016 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in OUT.
REQ-017 IDLE: in_valid=1 on an edge captures both inputs, -> CONV_X; otherwise stay.
REQ-018 CONV_X -> CONV_Y -> CHECK -> OUT unconditionally, one cycle each; out_valid rises exactly 3 edges after the accepting edge.
REQ-019 OUT: out_ready=1 -> IDLE; out_ready=0 -> stay, all outputs held bit-stable.
REQ-020 No back-to-back acceptance; minimum 4 cycles per pair, in_valid ignored outside IDLE.
REQ-021 Conversion per operand: e = exponent field, m = {1, mantissa} (24 bits), shift s = e - 127 + FRAC_BITS - 23; magnitude = m << s for s >= 0, m >> -s for s < 0 (truncate toward zero); result negated when sign = 1.
REQ-022 e = 0 (zero/denormal) SHALL yield 0 with no flag; -s >= 24 SHALL yield 0.
REQ-023 e = 255 SHALL yield 0 and set nan_flag.
REQ-024 Magnitude >= 2^31 SHALL saturate to +0x7FFFFFFF / -0x7FFFFFFF (symmetric) and set sat_flag.
REQ-025 CHECK: dom_err = 1 when x_fx <= 0, or |y_fx| >= x_fx, or nan_flag = 1; else 0.
REQ-026 Flags are per transaction: cleared on acceptance, never accumulated across pairs.

Reset
REQ-027 rst=1 on an edge SHALL force IDLE, in_ready=1, out_valid=0, x_fx=y_fx=0, all flags 0, regardless of state, including mid-conversion and during OUT stall.
REQ-028 A pair in flight when rst asserts SHALL be discarded, never emitted.
REQ-029 rst has priority over in_valid on the same edge.

Verification
REQ-030 x=0x3F800000 (1.0), y=0x3F0CCCCD (0.55), out_ready=1 -> 3 edges later x_fx=0x40000000, y_fx=0x23333340, all flags 0; in_ready back 1 next edge.
REQ-031 x=1.0, y=0xBF000000 (-0.5) then y=0x3A83126F (0.001) -> y_fx=0xE0000000, then y_fx=0x0010624D, dom_err=0.
REQ-032 x=1.0, y=0x3F800000 (1.0) -> dom_err=1; x=0xBF800000 (-1.0), y=0x3F400000 -> x_fx=0xC0000000, y_fx=0x30000000, dom_err=1.
REQ-033 y=0x40000000 (2.0) -> y_fx=0x7FFFFFFF, sat_flag=1, dom_err=1; y=0x7FC00000 (NaN) -> y_fx=0, nan_flag=1, dom_err=1; y=0x00000001 -> y_fx=0, no flags.
REQ-034 Hold out_ready=0 for 10 cycles in OUT -> outputs stable, in_ready=0, new in_valid ignored; release -> single transfer, IDLE.
REQ-035 Assert rst for one edge while in CONV_Y and while stalled in OUT -> next cycle in_ready=1, out_valid=0, outputs 0; no stale result later.
